// File: rtl/scroll_lane_bank.sv
// -----------------------------------------------------------------------------
// scroll_lane_bank
//
// Manages NUM_OBJ horizontally scrolling objects (pipes or clouds) with one
// shared update datapath. On every accepted frame start the bank walks the
// objects in order, one per clock. Each object moves left by STEP pixels.
// When an object reaches the left edge it wraps back to the right, so the
// spacing between objects stays exact. With RANDOM_Y=1 a wrapped object also
// gets a new pseudo-random height. A pass is counted each time an object
// crosses the bird's x position.
//
// Ports
//   Clk         system clock
//   Reset       synchronous, active-high; returns every register to its reset value
//   vs          VGA vertical sync; a rising edge is a frame start
//   run         1 = scroll on frame starts, 0 = frame starts are ignored
//   restart     synchronous game restart (positions, state, score only)
//   bird_x      bird reference x used for pass detection
//   obj_x       packed right-edge x, object i at [i*X_W +: X_W]
//   obj_y       packed y, object i at [i*Y_W +: Y_W]
//   score       number of passes, saturating at SCORE_MAX
//   pass_pulse  one-cycle pulse per counted pass
//   wrap_pulse  one-cycle pulse, bit i = object i wrapped
//   frame_done  one-cycle pulse after the last object was updated
//   busy        high while objects are being updated
//   overrun     sticky flag: a frame start arrived while busy
// -----------------------------------------------------------------------------
module scroll_lane_bank #(
    parameter int          NUM_OBJ   = 3,
    parameter int          X_W       = 11,
    parameter int          Y_W       = 10,
    parameter int          SPACING   = 213,
    parameter int          X_START   = 692,
    parameter int          STEP      = 1,
    parameter int          RANDOM_Y  = 1,
    parameter int          Y_INIT    = 180,
    parameter int          Y_MIN     = 100,
    parameter int          Y_MASK    = 255,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          SCORE_MAX = 999
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   vs,
    input  logic                   run,
    input  logic                   restart,
    input  logic [X_W-1:0]         bird_x,
    output logic [NUM_OBJ*X_W-1:0] obj_x,
    output logic [NUM_OBJ*Y_W-1:0] obj_y,
    output logic [9:0]             score,
    output logic                   pass_pulse,
    output logic [NUM_OBJ-1:0]     wrap_pulse,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun
);

    localparam int             IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [15:0]    LFSR_INIT = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;
    localparam logic [X_W-1:0] STEP_X    = X_W'(STEP);
    // Moving from the left edge to the back of the row is a single add of the
    // row span minus one step. Modulo 2^X_W this is exact because the span fits in X_W.
    localparam logic [X_W-1:0] WRAP_ADD  = X_W'(NUM_OBJ * SPACING - STEP);
    localparam logic [Y_W-1:0] Y_RST     = Y_W'(Y_INIT);
    localparam logic [Y_W-1:0] Y_BASE    = Y_W'(Y_MIN);
    localparam logic [15:0]    Y_MASK16  = 16'(Y_MASK);
    localparam logic [15:0]    LFSR_TAPS = 16'hB400;
    localparam logic [9:0]     SCORE_SAT = 10'(SCORE_MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_UPD  = 1'b1
    } state_t;

    function automatic logic [X_W-1:0] x_reset(input int i);
        return X_W'(X_START + i * SPACING);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vs_q;
    logic [9:0]         score_q, score_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               pass_q, pass_d;
    logic [NUM_OBJ-1:0] wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;

    logic [X_W-1:0]     x_q [NUM_OBJ];
    logic [Y_W-1:0]     y_q [NUM_OBJ];

    // ------------------------------------------------------------------
    // Shared datapath for the object selected by idx_q
    // ------------------------------------------------------------------
    logic               fs;
    logic               wr_en;
    logic [X_W-1:0]     cur_x, x_dec, x_wrap, new_x;
    logic [Y_W-1:0]     cur_y, rand_y, new_y;
    logic               wrap_now, pass_now;
    logic [15:0]        lfsr_step;

    assign fs = vs & ~vs_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        cur_x = '0;
        cur_y = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_x = x_q[i];
                cur_y = y_q[i];
            end
        end
    end

    assign wrap_now  = (cur_x <= STEP_X);
    assign x_dec     = cur_x - STEP_X;
    assign x_wrap    = cur_x + WRAP_ADD;
    assign new_x     = wrap_now ? x_wrap : x_dec;
    // A pass is counted only when the step moves the object from right of
    // the bird to on-or-left of it. A wrap never counts as a pass.
    assign pass_now  = ~wrap_now && (cur_x > bird_x) && (x_dec <= bird_x);
    // The new height uses the LFSR value from before this wrap's advance.
    assign rand_y    = Y_BASE + Y_W'(lfsr_q & Y_MASK16);
    assign new_y     = (wrap_now && (RANDOM_Y != 0)) ? rand_y : cur_y;
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // ------------------------------------------------------------------
    // Control: next state, counters and pulses
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        score_d = score_q;
        lfsr_d  = lfsr_q;
        ovr_d   = ovr_q;
        pass_d  = 1'b0;
        wrap_d  = '0;
        done_d  = 1'b0;
        wr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fs && run) begin
                    state_d = ST_UPD;
                    idx_d   = '0;
                end
            end
            ST_UPD: begin
                wr_en = 1'b1;
                // The frame in progress always completes. A new frame start is
                // dropped and flagged.
                if (fs) begin
                    ovr_d = 1'b1;
                end
                if (wrap_now) begin
                    wrap_d = NUM_OBJ'(1) << idx_q;
                    if (RANDOM_Y != 0) begin
                        lfsr_d = lfsr_step;
                    end
                end
                if (pass_now) begin
                    pass_d = 1'b1;
                    if (score_q < SCORE_SAT) begin
                        score_d = score_q + 10'd1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        // Restart overrides any update in this cycle. The LFSR and the
        // overrun flag keep their values, so a restart does not replay the
        // same heights.
        if (restart) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            score_d = '0;
            lfsr_d  = lfsr_q;
            ovr_d   = ovr_q;
            pass_d  = 1'b0;
            wrap_d  = '0;
            done_d  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples the values from before this edge, whatever the statement order.
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vs_q    <= 1'b0;
            score_q <= '0;
            lfsr_q  <= LFSR_INIT;
            pass_q  <= 1'b0;
            wrap_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vs_q    <= vs;
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
            pass_q  <= pass_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Object table. Restart returns x and y to their power-on layout.
    always_ff @(posedge Clk) begin
        // NOTE: this small table is made of flops with defined per-entry reset
        // values, not a RAM. It must be reset, because the visible layout
        // after reset depends on it.
        if (Reset || restart) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_q[i] <= x_reset(i);
                y_q[i] <= Y_RST;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    x_q[i] <= new_x;
                    y_q[i] <= new_y;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_pack
        assign obj_x[g*X_W +: X_W] = x_q[g];
        assign obj_y[g*Y_W +: Y_W] = y_q[g];
    end

    assign score      = score_q;
    assign pass_pulse = pass_q;
    assign wrap_pulse = wrap_q;
    assign frame_done = done_q;
    assign busy       = (state_q == ST_UPD);
    assign overrun    = ovr_q;

endmodule
